// File: rtl/instr_buf_pkg.sv
// Shared types and constants for the instruction-buffer read path.
package instr_buf_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 6;
  localparam int SKID_DEPTH = 2;

  // Reader control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/instr_buf_reader_if.sv
// Buffer-side read port and downstream valid/ready port of the reader.
interface instr_buf_reader_if #(
  parameter int DATA_WIDTH = instr_buf_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = instr_buf_pkg::ADDR_WIDTH
);

  logic                  buf_empty;
  logic                  buf_rd_en;
  logic [ADDR_WIDTH-1:0] buf_rd_addr;
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_addr;

  // Reader side.
  modport master (
    input  buf_empty, buf_data, out_ready,
    output buf_rd_en, buf_rd_addr, out_valid, out_data, out_addr
  );

  // Buffer / downstream side.
  modport slave (
    output buf_empty, buf_data, out_ready,
    input  buf_rd_en, buf_rd_addr, out_valid, out_data, out_addr
  );

endinterface

// File: rtl/instr_skid_buf.sv
// Small synchronous FIFO holding {addr, data} pairs between the buffer read
// port and the downstream handshake. The head entry is always visible.
module instr_skid_buf #(
  parameter int WIDTH = instr_buf_pkg::ADDR_WIDTH + instr_buf_pkg::DATA_WIDTH,
  parameter int DEPTH = instr_buf_pkg::SKID_DEPTH,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [OCC_W-1:0] occ,
  output logic [WIDTH-1:0] head_data
);
  import instr_buf_pkg::*;

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [IDX_W-1:0] wr_idx_reg;
  logic [IDX_W-1:0] rd_idx_reg;
  logic [OCC_W-1:0] occ_reg;
  logic             pop_fire;
  logic             push_fire;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + 1'b1;
  endfunction

  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign pop_fire  = pop && (occ_reg != '0);
  assign push_fire = push && ((occ_reg != OCC_W'(DEPTH)) || pop_fire);

  // Per-entry storage; reset to zero so the head reads as zero out of reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (rst) begin
        mem_reg[gi] <= '0;
      end else if (push_fire && !clear && (wr_idx_reg == IDX_W'(gi))) begin
        mem_reg[gi] <= push_data;
      end
    end
  end

  // Pointers and occupancy; clear discards everything held.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_idx_reg <= '0;
      rd_idx_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (push_fire) wr_idx_reg <= next_idx(wr_idx_reg);
      if (pop_fire)  rd_idx_reg <= next_idx(rd_idx_reg);
      case ({push_fire, pop_fire})
        2'b10:   occ_reg <= occ_reg + 1'b1;
        2'b01:   occ_reg <= occ_reg - 1'b1;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  assign occ       = occ_reg;
  assign head_data = mem_reg[rd_idx_reg];

endmodule

// File: rtl/instr_buf_reader.sv
// Read-side controller for the instruction buffer: issues reads, absorbs the
// one-cycle read latency, and presents words in order with their address.
module instr_buf_reader #(
  parameter int DATA_WIDTH = instr_buf_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = instr_buf_pkg::ADDR_WIDTH,
  parameter int DATA_DEPTH = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_addr,
  instr_buf_reader_if.master    bus
);
  import instr_buf_pkg::*;

  localparam int OCC_W   = $clog2(SKID_DEPTH + 1);
  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

  state_t                state_reg;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg;
  logic [ADDR_WIDTH-1:0] rd_ptr_next;
  logic                  inflight_reg;
  logic [ADDR_WIDTH-1:0] inflight_addr_reg;
  logic [OCC_W-1:0]      occ;
  logic [OCC_W:0]        demand;
  logic [ENTRY_W-1:0]    head_entry;
  logic                  pop;
  logic                  push;
  logic                  rd_en;

  assign pop = bus.out_valid && bus.out_ready;

  // Words held or arriving after this cycle, if no new read were issued.
  assign demand = (OCC_W + 1)'(occ) + (OCC_W + 1)'(inflight_reg) - (OCC_W + 1)'(pop);

  // A returning word is killed by a flush in its landing cycle; a flush in the
  // issue cycle never issues, so this gate covers every in-flight read.
  assign push = inflight_reg && !flush;

  // Read issue: only in RUN, never on flush, never from an empty buffer.
  always_comb begin
    rd_en = 1'b0;
    if (!rst && !flush && (state_reg == RUN) && !bus.buf_empty &&
        (demand < (OCC_W + 1)'(SKID_DEPTH))) begin
      rd_en = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; flush overrides every state.
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = FLUSH;
    end else begin
      case (state_reg)
        IDLE:    if (enable) state_next = RUN;
        RUN:     if (!enable) state_next = IDLE;
        FLUSH:   state_next = enable ? RUN : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Read pointer: redirect on flush, otherwise advance per issued read.
  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    if (flush) begin
      rd_ptr_next = flush_addr;
    end else if (rd_en) begin
      rd_ptr_next = (rd_ptr_reg == ADDR_WIDTH'(DATA_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) rd_ptr_reg <= '0;
    else     rd_ptr_reg <= rd_ptr_next;
  end

  // Track the outstanding read and the address it was issued at.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_reg      <= 1'b0;
      inflight_addr_reg <= '0;
    end else begin
      inflight_reg <= rd_en;
      if (rd_en) inflight_addr_reg <= rd_ptr_reg;
    end
  end

  instr_skid_buf #(
    .WIDTH (ENTRY_W),
    .DEPTH (SKID_DEPTH),
    .OCC_W (OCC_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .push_data ({inflight_addr_reg, bus.buf_data}),
    .pop       (pop && !flush),
    .occ       (occ),
    .head_data (head_entry)
  );

  assign bus.buf_rd_en   = rd_en;
  assign bus.buf_rd_addr = rd_ptr_reg;
  assign bus.out_valid   = (occ != '0);
  assign bus.out_data    = head_entry[DATA_WIDTH-1:0];
  assign bus.out_addr    = head_entry[ENTRY_W-1 -: ADDR_WIDTH];

endmodule

// File: tb/tb_instr_buf_reader.sv
// Self-checking bench for instr_buf_reader: directed scenarios plus a
// randomized phase, all checked against a sequential-address reference model.
module tb_instr_buf_reader;

  localparam int DW = 32;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          flush;
  logic [AW-1:0] flush_addr;

  instr_buf_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  instr_buf_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DATA_DEPTH(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .flush      (flush),
    .flush_addr (flush_addr),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Buffer model: registered read of mem, word count drives buf_empty.
  logic [DW-1:0] mem [64];
  int            avail    = 0;
  int            load_val = 0;
  logic          rand_empty;

  assign bus.buf_empty = (avail == 0) || rand_empty;

  always @(posedge clk) begin
    avail <= avail + load_val - (bus.buf_rd_en ? 1 : 0);
    if (bus.buf_rd_en) bus.buf_data <= mem[bus.buf_rd_addr];
    else               bus.buf_data <= $urandom;
  end

  // Reference model: reads go out at consecutive addresses from the last
  // restart point, and delivered words follow the same sequence.
  logic [AW-1:0] exp_issue = '0;
  logic [AW-1:0] exp_out   = '0;
  int            pending   = 0;
  int            n_out     = 0;
  logic          hold      = 1'b0;
  logic [DW-1:0] hold_data;
  logic [AW-1:0] hold_addr;
  logic          flush_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_issue  = '0;
      exp_out    = '0;
      pending    = 0;
      hold       = 1'b0;
      flush_prev = 1'b0;
    end else begin
      if (flush_prev) begin
        check_eq("after_flush_valid", bus.out_valid, 1'b0);
        check_eq("after_flush_rd_en", bus.buf_rd_en, 1'b0);
      end
      if (hold) begin
        check_eq("hold_valid", bus.out_valid, 1'b1);
        check_eq("hold_data", bus.out_data, hold_data);
        check_eq("hold_addr", bus.out_addr, hold_addr);
      end
      if (bus.buf_rd_en) check_eq("rd_en_while_empty", bus.buf_empty, 1'b0);
      if (flush) begin
        check_eq("flush_cycle_rd_en", bus.buf_rd_en, 1'b0);
        exp_issue = flush_addr;
        exp_out   = flush_addr;
        pending   = 0;
        hold      = 1'b0;
      end else begin
        if (bus.buf_rd_en) begin
          check_eq("rd_addr", bus.buf_rd_addr, exp_issue);
          exp_issue = exp_issue + 1'b1;
          pending++;
        end
        if (bus.out_valid && bus.out_ready) begin
          $display("OUT addr=0x%02h data=0x%08h", bus.out_addr, bus.out_data);
          check_eq("out_addr", bus.out_addr, exp_out);
          check_eq("out_data", bus.out_data, mem[exp_out]);
          exp_out = exp_out + 1'b1;
          pending--;
          n_out++;
        end
        if (bus.buf_rd_en) check_eq("outstanding_le_2", pending <= 2, 1'b1);
        hold      = bus.out_valid && !bus.out_ready;
        hold_data = bus.out_data;
        hold_addr = bus.out_addr;
      end
      flush_prev = flush;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic add_words(input int n);
    load_val = n;
    step();
    load_val = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rd_en"}, bus.buf_rd_en, 1'b0);
    check_eq({tag, "_rd_addr"}, bus.buf_rd_addr, '0);
    check_eq({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check_eq({tag, "_out_data"}, bus.out_data, '0);
    check_eq({tag, "_out_addr"}, bus.out_addr, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int iss_cyc[$];
    int val_cyc[$];
    logic [AW-1:0] iss_addr[$];
    logic [AW-1:0] val_addr[$];
    logic [DW-1:0] val_data[$];
    int cnt;
    int out_before;
    logic seen;

    rst = 1'b1; enable = 1'b0; flush = 1'b0; flush_addr = '0;
    bus.out_ready = 1'b0; rand_empty = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'hA0; mem[1] = 32'hA1; mem[2] = 32'hA2;
    repeat (3) step();
    sample();
    check_reset_outputs("reset");

    // Enabled with an empty buffer: nothing may be read.
    step();
    rst = 1'b0; enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sample();
      check_eq("empty_rd_en", bus.buf_rd_en, 1'b0);
      check_eq("empty_rd_addr", bus.buf_rd_addr, '0);
      check_eq("empty_out_valid", bus.out_valid, 1'b0);
    end

    // Three words, free-flowing downstream.
    step();
    bus.out_ready = 1'b1;
    add_words(3);
    for (int c = 0; c < 10; c++) begin
      sample();
      if (bus.buf_rd_en) iss_cyc.push_back(c);
      if (bus.out_valid) begin
        val_cyc.push_back(c);
        val_addr.push_back(bus.out_addr);
        val_data.push_back(bus.out_data);
      end
    end
    check_eq("t2_issue_count", iss_cyc.size(), 3);
    check_eq("t2_valid_count", val_cyc.size(), 3);
    if (iss_cyc.size() == 3 && val_cyc.size() == 3) begin
      check_eq("t2_issue_consecutive", iss_cyc[2] - iss_cyc[0], 2);
      check_eq("t2_latency", val_cyc[0] - iss_cyc[0], 2);
      check_eq("t2_valid_consecutive", val_cyc[2] - val_cyc[0], 2);
      for (int i = 0; i < 3; i++) begin
        check_eq("t2_out_addr", val_addr[i], i);
        check_eq("t2_out_data", val_data[i], 32'hA0 + i);
      end
    end

    // Backpressure: eight words available, downstream stalled.
    step();
    bus.out_ready = 1'b0;
    add_words(8);
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      sample();
      if (bus.buf_rd_en) cnt++;
    end
    check_eq("t3_stall_issues", cnt, 2);
    check_eq("t3_stall_valid", bus.out_valid, 1'b1);
    step();
    bus.out_ready = 1'b1;
    out_before = n_out;
    cnt = 0;
    for (int c = 0; c < 14; c++) begin
      sample();
      if (bus.buf_rd_en) cnt++;
    end
    check_eq("t3_drain_issues", cnt, 6);
    check_eq("t3_delivered", n_out - out_before, 8);

    // Pointer wrap: restart at 62 with four words.
    step();
    flush = 1'b1; flush_addr = 6'd62;
    step();
    flush = 1'b0;
    add_words(4);
    iss_addr.delete(); val_addr.delete();
    for (int c = 0; c < 12; c++) begin
      sample();
      if (bus.buf_rd_en) iss_addr.push_back(bus.buf_rd_addr);
      if (bus.out_valid && bus.out_ready) val_addr.push_back(bus.out_addr);
    end
    check_eq("t4_issue_count", iss_addr.size(), 4);
    check_eq("t4_out_count", val_addr.size(), 4);
    if (iss_addr.size() == 4 && val_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check_eq("t4_issue_addr", iss_addr[i], (62 + i) % 64);
        check_eq("t4_out_addr", val_addr[i], (62 + i) % 64);
      end
    end

    // Flush with one word held and one read in flight.
    step();
    bus.out_ready = 1'b0;
    add_words(1);
    add_words(1);
    step();
    flush = 1'b1; flush_addr = 6'h10; load_val = 4;
    sample();
    check_eq("t5_pre_flush_valid", bus.out_valid, 1'b1);
    check_eq("t5_flush_rd_en", bus.buf_rd_en, 1'b0);
    step();
    flush = 1'b0; load_val = 0;
    sample();
    check_eq("t5_post_flush_valid", bus.out_valid, 1'b0);
    check_eq("t5_flush_state_rd_en", bus.buf_rd_en, 1'b0);
    step();
    sample();
    check_eq("t5_first_read_en", bus.buf_rd_en, 1'b1);
    check_eq("t5_first_read_addr", bus.buf_rd_addr, 6'h10);
    step();
    bus.out_ready = 1'b1;
    val_addr.delete();
    for (int c = 0; c < 10; c++) begin
      sample();
      if (bus.out_valid && bus.out_ready) val_addr.push_back(bus.out_addr);
    end
    check_eq("t5_out_count", val_addr.size(), 4);
    if (val_addr.size() > 0) check_eq("t5_first_out_addr", val_addr[0], 6'h10);

    // Reset in the middle of a stalled stream.
    step();
    bus.out_ready = 1'b0;
    add_words(2);
    repeat (4) sample();
    check_eq("t6_pre_reset_valid", bus.out_valid, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sample();
    check_reset_outputs("t6_mid_reset");
    step();
    bus.out_ready = 1'b1;
    add_words(3);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      sample();
      if (bus.buf_rd_en) begin
        seen = 1'b1;
        check_eq("t6_restart_addr", bus.buf_rd_addr, '0);
      end
    end
    check_eq("t6_restart_seen", seen, 1'b1);

    // Randomized traffic; the monitor checks every transfer.
    repeat (12) sample();
    step();
    load_val = 1_000_000;
    step();
    load_val = 0;
    out_before = n_out;
    for (int c = 0; c < 3000; c++) begin
      bus.out_ready = ($urandom % 4) != 0;
      rand_empty    = ($urandom % 5) == 0;
      enable        = ($urandom % 30) != 0;
      flush         = ($urandom % 50) == 0;
      flush_addr    = AW'($urandom);
      rst           = ($urandom % 700) == 0;
      step();
    end
    rst = 1'b0; flush = 1'b0; enable = 1'b1; bus.out_ready = 1'b1; rand_empty = 1'b0;
    repeat (10) step();
    check_eq("random_progress", (n_out - out_before) > 800, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
